// File: rtl/d_shift_pkg.sv
// Shared operation encodings for the d_shift_reg register family.
package d_shift_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;
  localparam mode_t MODE_RSV  = 3'b111;

endpackage

// File: rtl/d_ff_en.sv
// Single-bit D flop with synchronous active-high reset, clock enable and
// true/complement outputs.
module d_ff_en #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (en)
      q <= d;
  end

  assign qb = ~q;

endmodule

// File: rtl/d_shift_reg.sv
// WIDTH-bit mode-selected shift/rotate/load register with a saturating
// shift counter, usable as a parallel-to-serial converter.
module d_shift_reg
  import d_shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] cnt,
  output logic             drained
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_p0;
  logic [WIDTH-1:0] qb_p0;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] ror_v;
  logic [CNT_W-1:0] cnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Neighbour taps per bit; edge bits take the serial input or the wrapped bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lo
      assign shl_v[i] = sin_lsb;
      assign rol_v[i] = q_p0[WIDTH-1];
    end else begin : g_lo_n
      assign shl_v[i] = q_p0[i-1];
      assign rol_v[i] = q_p0[i-1];
    end

    if (i == WIDTH - 1) begin : g_hi
      assign shr_v[i] = sin_msb;
      assign ror_v[i] = q_p0[0];
    end else begin : g_hi_n
      assign shr_v[i] = q_p0[i+1];
      assign ror_v[i] = q_p0[i+1];
    end

    d_ff_en #(
      .RST_VAL(RST_VAL[i])
    ) u_ff (
      .clk(clk),
      .rst(Rst),
      .en (en),
      .d  (q_nxt[i]),
      .q  (q_p0[i]),
      .qb (qb_p0[i])
    );
  end

  always_comb begin
    q_nxt = q_p0;
    case (mode)
      MODE_LOAD:           q_nxt = D;
      MODE_SHL:            q_nxt = shl_v;
      MODE_SHR:            q_nxt = shr_v;
      MODE_ROL:            q_nxt = rol_v;
      MODE_ROR:            q_nxt = ror_v;
      MODE_CLR:            q_nxt = '0;
      MODE_HOLD, MODE_RSV: q_nxt = q_p0;
      default:             q_nxt = q_p0;
    endcase
  end

  // Register stage: shift counter, cleared by load/clear and by reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_p0 <= '0;
    end else if (en) begin
      case (mode)
        MODE_LOAD, MODE_CLR: cnt_p0 <= '0;
        MODE_SHL, MODE_SHR:  cnt_p0 <= sat_inc(cnt_p0);
        default:             cnt_p0 <= cnt_p0;
      endcase
    end
  end

  assign Q        = q_p0;
  assign Qb       = qb_p0;
  assign sout_msb = q_p0[WIDTH-1];
  assign sout_lsb = q_p0[0];
  assign cnt      = cnt_p0;
  assign drained  = (cnt_p0 == CNT_MAX);

endmodule

// File: tb/tb_d_shift_reg.sv
// Bench for d_shift_reg: three instances (8-bit reset 00, 8-bit reset 3C,
// 1-bit reset 1) driven in lockstep and compared to an arithmetic model.
module tb_d_shift_reg;

  logic       clk = 1'b0;
  logic       Rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] D;
  logic       sin_lsb;
  logic       sin_msb;

  logic [7:0] q0, qb0, q1, qb1;
  logic [0:0] q2, qb2;
  logic       som0, sol0, som1, sol1, som2, sol2;
  logic [3:0] cnt0, cnt1;
  logic [0:0] cnt2;
  logic       dr0, dr1, dr2;

  int checks = 0;
  int errors = 0;
  int warns  = 0;

  int mw [3] = '{8, 8, 1};
  int mrv[3] = '{32'h00, 32'h3C, 32'h1};
  int mq [3];
  int mc [3];

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  d_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut0 (
    .clk(clk), .Rst(Rst), .en(en), .mode(mode), .D(D),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .Q(q0), .Qb(qb0),
    .sout_msb(som0), .sout_lsb(sol0), .cnt(cnt0), .drained(dr0));

  d_shift_reg #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut1 (
    .clk(clk), .Rst(Rst), .en(en), .mode(mode), .D(D),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .Q(q1), .Qb(qb1),
    .sout_msb(som1), .sout_lsb(sol1), .cnt(cnt1), .drained(dr1));

  d_shift_reg #(.WIDTH(1), .RST_VAL(1'b1)) u_dut2 (
    .clk(clk), .Rst(Rst), .en(en), .mode(mode), .D(D[0:0]),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .Q(q2), .Qb(qb2),
    .sout_msb(som2), .sout_lsb(sol2), .cnt(cnt2), .drained(dr2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the register as an integer, shifts as plain arithmetic.
  task automatic model_step(input int k, input int d, input int sl, input int sm);
    int mask;
    mask = (1 << mw[k]) - 1;
    if (Rst) begin
      mq[k] = mrv[k];
      mc[k] = 0;
    end else if (en) begin
      case (mode)
        3'd1: begin mq[k] = d & mask; mc[k] = 0; end
        3'd2: begin mq[k] = ((mq[k] << 1) | sl) & mask; mc[k] = (mc[k] < mw[k]) ? mc[k] + 1 : mw[k]; end
        3'd3: begin mq[k] = (mq[k] >> 1) | (sm << (mw[k] - 1)); mc[k] = (mc[k] < mw[k]) ? mc[k] + 1 : mw[k]; end
        3'd4: mq[k] = ((mq[k] << 1) | (mq[k] >> (mw[k] - 1))) & mask;
        3'd5: mq[k] = (mq[k] >> 1) | ((mq[k] & 1) << (mw[k] - 1));
        3'd6: begin mq[k] = 0; mc[k] = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    int m0, m1, m2;
    m0 = (1 << mw[0]) - 1;
    m1 = (1 << mw[1]) - 1;
    m2 = (1 << mw[2]) - 1;
    check("q0", 32'(q0), 32'(mq[0]));
    check("qb0", 32'(qb0), 32'(~mq[0] & m0));
    check("som0", 32'(som0), 32'((mq[0] >> 7) & 1));
    check("sol0", 32'(sol0), 32'(mq[0] & 1));
    check("cnt0", 32'(cnt0), 32'(mc[0]));
    check("dr0", 32'(dr0), 32'(mc[0] == 8));
    check("q1", 32'(q1), 32'(mq[1]));
    check("qb1", 32'(qb1), 32'(~mq[1] & m1));
    check("cnt1", 32'(cnt1), 32'(mc[1]));
    check("dr1", 32'(dr1), 32'(mc[1] == 8));
    check("q2", 32'(q2), 32'(mq[2]));
    check("qb2", 32'(qb2), 32'(~mq[2] & m2));
    check("som2", 32'(som2), 32'(mq[2]));
    check("sol2", 32'(sol2), 32'(mq[2]));
    check("cnt2", 32'(cnt2), 32'(mc[2]));
    check("dr2", 32'(dr2), 32'(mc[2] == 1));
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] d, input logic sl, input logic sm);
    int di, sli, smi;
    Rst = r; en = e; mode = m; D = d; sin_lsb = sl; sin_msb = sm;
    if (e && !r && m == 3'd7 && warns < 3) begin
      warns++;
      $display("warning: reserved mode 111 applied (treated as hold)");
    end
    di  = int'(d);
    sli = int'(sl);
    smi = int'(sm);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, di, sli, smi);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] rm;
    logic       re, rr;
    logic [7:0] rd;
    logic       rsl, rsm;

    Rst = 1'b1; en = 1'b1; mode = 3'd1; D = 8'hFF; sin_lsb = 1'b0; sin_msb = 1'b0;
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mc[k] = 0; end
    @(negedge clk);

    // Reset dominates a pending load
    step(1, 1, 3'd1, 8'hFF, 0, 0);
    step(1, 1, 3'd1, 8'hFF, 0, 0);
    check("rst_q", 32'(q0), 32'h00);
    check("rst_qb", 32'(qb0), 32'hFF);
    check("rst_cnt", 32'(cnt0), 32'h0);
    check("rst_dr", 32'(dr0), 32'h0);
    check("rst_q1", 32'(q1), 32'h3C);
    check("rst_q2", 32'(q2), 32'h1);
    step(0, 1, 3'd0, 8'hFF, 0, 0);
    check("hold_after_rst", 32'(q0), 32'h00);

    // Load then enable-low hold
    step(0, 1, 3'd1, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'd2, 8'h00, 1, 1);
      check("en0_q", 32'(q0), 32'hA5);
      check("en0_cnt", 32'(cnt0), 32'h0);
    end
    step(0, 1, 3'd0, 8'h00, 1, 1);
    check("hold_q", 32'(q0), 32'hA5);

    // Serial drain
    step(0, 1, 3'd1, 8'hA5, 0, 0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("drain_sout", 32'(som0), 32'(pat[7-i]));
      step(0, 1, 3'd2, 8'h00, 0, 0);
    end
    check("drain_q", 32'(q0), 32'h00);
    check("drain_cnt", 32'(cnt0), 32'h8);
    check("drain_dr", 32'(dr0), 32'h1);
    check("drain_dr_w1", 32'(dr2), 32'h1);
    step(0, 1, 3'd2, 8'h00, 1, 0);
    check("sat_cnt", 32'(cnt0), 32'h8);
    check("sat_q", 32'(q0), 32'h01);

    // Shift right with ones fill
    step(0, 1, 3'd1, 8'h01, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd3, 8'h00, 0, 1);
    check("shr_q", 32'(q0), 32'hF0);
    check("shr_cnt", 32'(cnt0), 32'h4);
    check("shr_dr", 32'(dr0), 32'h0);

    // Rotates
    step(0, 1, 3'd1, 8'h81, 0, 0);
    step(0, 1, 3'd4, 8'h00, 0, 0);
    check("rol_q", 32'(q0), 32'h03);
    step(0, 1, 3'd5, 8'h00, 0, 0);
    step(0, 1, 3'd5, 8'h00, 0, 0);
    check("ror_q", 32'(q0), 32'hC0);
    check("rot_cnt", 32'(cnt0), 32'h0);

    // Reset mid-drain on the RST_VAL=3C instance, then clear
    step(0, 1, 3'd1, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd2, 8'h00, 0, 0);
    check("mid_cnt", 32'(cnt1), 32'h3);
    step(1, 1, 3'd2, 8'h00, 0, 0);
    check("mid_rst_q", 32'(q1), 32'h3C);
    check("mid_rst_qb", 32'(qb1), 32'hC3);
    check("mid_rst_cnt", 32'(cnt1), 32'h0);
    step(0, 1, 3'd1, 8'h5A, 0, 0);
    step(0, 1, 3'd6, 8'hFF, 1, 1);
    check("clr_q", 32'(q0), 32'h00);
    check("clr_cnt", 32'(cnt0), 32'h0);

    // Reserved mode holds
    step(0, 1, 3'd1, 8'h6B, 0, 0);
    step(0, 1, 3'd7, 8'hFF, 1, 1);
    check("rsv_q", 32'(q0), 32'h6B);

    // Random traffic; inputs a mode ignores are driven to X
    for (int n = 0; n < 400; n++) begin
      rm  = 3'($urandom_range(0, 7));
      re  = ($urandom_range(0, 7) != 0);
      rr  = ($urandom_range(0, 31) == 0);
      rd  = 8'($urandom);
      rsl = 1'($urandom);
      rsm = 1'($urandom);
      if (rm != 3'd1 && $urandom_range(0, 1) == 1) rd  = 8'hxx;
      if (rm != 3'd2) rsl = 1'bx;
      if (rm != 3'd3) rsm = 1'bx;
      step(rr, re, rm, rd, rsl, rsm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_shift_reg.md
Name: d_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop.
- WIDTH-bit register with true and complement outputs.
- Supports a mode-selected next-state: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, and clear.
- Tracks the number of shifts since the last load, so it can act as a parallel-to-serial converter feeding serial links elsewhere in the design.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 1.
- RST_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; not overridden by users).

Ports:
- clk  in  1  rising-edge clock
- Rst  in  1  reset; synchronous, active-high
- en  in  1  clock enable; 0 = hold all state
- mode  in  3  operation select (see Behaviour)
- D  in  WIDTH  parallel load data
- sin_lsb  in  1  serial bit entering bit 0 on shift left
- sin_msb  in  1  serial bit entering bit WIDTH-1 on shift right
- Q  out  WIDTH  register contents
- Qb  out  WIDTH  bitwise complement of Q
- sout_msb  out  1  Q[WIDTH-1]
- sout_lsb  out  1  Q[0]
- cnt  out  CNT_W  shifts since last load/clear, saturating at WIDTH
- drained  out  1  high when cnt == WIDTH

Behaviour:
- All state updates on rising clk only. No asynchronous paths into the flops.
- Reset: Rst=1 at a rising edge gives Q=RST_VAL, Qb=~RST_VAL, cnt=0, drained=0.
  - Rst has priority over en and mode.
  - Reset asserted mid-sequence discards the operation in that cycle.
- en=0 (Rst=0): Q and cnt hold regardless of mode.
- en=1, mode encoding:
  - 000 hold: Q, cnt unchanged.
  - 001 load: Q<=D, cnt<=0.
  - 010 shl: Q<={Q[WIDTH-2:0],sin_lsb}; cnt<=min(cnt+1,WIDTH).
  - 011 shr: Q<={sin_msb,Q[WIDTH-1:1]}; cnt<=min(cnt+1,WIDTH).
  - 100 rol: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; cnt unchanged.
  - 101 ror: Q<={Q[0],Q[WIDTH-1:1]}; cnt unchanged.
  - 110 clear: Q<=0, cnt<=0.
  - 111 reserved: behaves as hold. Bench flags it as a warning, not an error.
- Latency: one cycle from the sampled inputs to the new Q/cnt.
- Qb, sout_msb, sout_lsb and drained are combinational from registered state. There is no extra delay and no path from the inputs.
- Counter:
  - Saturates at WIDTH; further shifts keep cnt=WIDTH and drained=1.
  - Shifting continues to modify Q after saturation.
- WIDTH=1:
  - shl gives Q<=sin_lsb; shr gives Q<=sin_msb.
  - rol/ror hold Q.
  - CNT_W=1; drained after one shift.
- D and the serial inputs are sampled only in modes that use them. X on an unused input must not propagate into Q.

Decomposition:
- Package d_shift_pkg holds:
  - mode localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR, MODE_RSV;
  - a mode_t 3-bit typedef.
- One sub-module, d_ff_en: a single-bit flop with synchronous active-high Rst, reset value, enable and Q/Qb.
  - Generated WIDTH times.
  - The per-bit next-state mux lives in d_shift_reg.
  - The counter lives inline in d_shift_reg.

Test Plan (WIDTH=8, RST_VAL=8'h00 unless stated):
- Reset: Rst=1 for 2 cycles with en=1, mode=LOAD, D=8'hFF -> Q=8'h00, Qb=8'hFF, cnt=0, drained=0; after Rst=0 with mode=HOLD, Q stays 8'h00.
- Load and hold: load D=8'hA5, then en=0 with mode=SHL for 3 cycles -> Q=8'hA5 throughout, cnt=0; then en=1, mode=HOLD -> Q=8'hA5.
- Serial drain: load 8'hA5, then 8 cycles of SHL with sin_lsb=0 -> sout_msb sequence 1,0,1,0,0,1,0,1; final Q=8'h00, cnt=8, drained=1. A 9th SHL keeps cnt=8.
- Shift right fill: load 8'h01, 4 cycles of SHR with sin_msb=1 -> Q=8'hF0, cnt=4, drained=0.
- Rotate: load 8'h81, ROL -> 8'h03, ROR twice -> 8'hC0; cnt stays 0.
- Reset mid-drain with RST_VAL=8'h3C: load 8'hFF, SHL x3 (cnt=3), Rst=1 during the 4th SHL -> Q=8'h3C, Qb=8'hC3, cnt=0. CLR after a load gives Q=0, cnt=0.
